// File: rtl/i1_enc_pkg.sv
// Shared types and constants for the i1 request encoder.
// Provides the FSM state enum, the command word struct and a channel decoder.
package i1_enc_pkg;

    localparam int CHAN_W  = 3;
    localparam int N_LINES = 7;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RELEASE
    } state_t;

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic [1:0]        mode;
        logic              prio;
    } cmd_t;

    // Channel 0 means "no line"; channel k lights line k-1.
    function automatic logic [N_LINES-1:0] chan_decode(
        input logic [CHAN_W-1:0] chan
    );
        logic [N_LINES-1:0] lines;
        lines = '0;
        if (chan != '0) begin
            lines[chan - CHAN_W'(1)] = 1'b1;
        end
        return lines;
    endfunction

endpackage

// File: rtl/i1_enc_fifo.sv
// Synchronous command FIFO of cmd_t words with a registered fill count.
// Ports: clk, rst_n (sync, active-low), push/push_data, pop/pop_data, full, empty, count.
module i1_enc_fifo
    import i1_enc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  cmd_t                     push_data,
    input  logic                     pop,
    output cmd_t                     pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    cmd_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i1_req_encoder.sv
// Buffers command words and replays each onto the i1 request bus as SETUP/STROBE/RELEASE.
// Ports: clk, rst_n (sync, active-low), cmd_valid/cmd_ready/cmd_chan/cmd_mode/cmd_prio in,
//        req_lines, sel_lo, sel_hi, prio, strobe, busy, issued_cnt out.
module i1_req_encoder
    import i1_enc_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CHAN_W-1:0]   cmd_chan,
    input  logic [1:0]          cmd_mode,
    input  logic                cmd_prio,
    output logic [N_LINES-1:0]  req_lines,
    output logic                sel_lo,
    output logic                sel_hi,
    output logic                prio,
    output logic                strobe,
    output logic                busy,
    output logic [CNT_W-1:0]    issued_cnt
);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    state_t                     state;
    logic [HW-1:0]              hold_cnt;
    logic [CNT_W-1:0]           cnt_q;
    logic                       ready_en;
    cmd_t                       in_word;
    cmd_t                       head;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic [$clog2(FIFO_DEPTH):0] fill;

    assign in_word    = '{chan: cmd_chan, mode: cmd_mode, prio: cmd_prio};
    // ready_en keeps cmd_ready low while reset is held.
    assign cmd_ready  = ready_en && !full;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == IDLE || state == RELEASE) && !empty;
    assign busy       = (state != IDLE) || !empty;
    assign issued_cnt = cnt_q;

    i1_enc_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_word),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fill)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            cnt_q     <= '0;
            ready_en  <= 1'b0;
            req_lines <= '0;
            sel_lo    <= 1'b0;
            sel_hi    <= 1'b0;
            prio      <= 1'b0;
            strobe    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            unique case (state)
                IDLE, RELEASE: begin
                    if (!empty) begin
                        req_lines <= chan_decode(head.chan);
                        sel_lo    <= head.mode[0];
                        sel_hi    <= head.mode[1];
                        prio      <= head.prio;
                        state     <= SETUP;
                    end else begin
                        state     <= IDLE;
                    end
                end
                SETUP: begin
                    strobe   <= 1'b1;
                    hold_cnt <= HOLD_LOAD;
                    state    <= STROBE;
                end
                STROBE: begin
                    if (hold_cnt == '0) begin
                        req_lines <= '0;
                        sel_lo    <= 1'b0;
                        sel_hi    <= 1'b0;
                        prio      <= 1'b0;
                        strobe    <= 1'b0;
                        cnt_q     <= cnt_q + CNT_W'(1);
                        state     <= RELEASE;
                    end else begin
                        hold_cnt  <= hold_cnt - HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i1_req_encoder.sv
// Directed bench for i1_req_encoder (HOLD_CYCLES=2, FIFO_DEPTH=4).
// Checks latency, channel decode, back-pressure, reset flush and counter wrap.
module tb_i1_req_encoder;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_chan;
    logic [1:0]  cmd_mode;
    logic        cmd_prio;
    logic [6:0]  req_lines;
    logic        sel_lo;
    logic        sel_hi;
    logic        prio;
    logic        strobe;
    logic        busy;
    logic [15:0] issued_cnt;

    int compared;
    int mismatched;

    i1_req_encoder #(
        .HOLD_CYCLES (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_chan   (cmd_chan),
        .cmd_mode   (cmd_mode),
        .cmd_prio   (cmd_prio),
        .req_lines  (req_lines),
        .sel_lo     (sel_lo),
        .sel_hi     (sel_hi),
        .prio       (prio),
        .strobe     (strobe),
        .busy       (busy),
        .issued_cnt (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] bus_now();
        return {req_lines, sel_hi, sel_lo, prio, strobe};
    endfunction

    function automatic logic [10:0] bus_exp(input logic [6:0] l, input logic [1:0] m,
                                           input logic p, input logic s);
        return {l, m, p, s};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [1:0] m, input logic p);
        cmd_valid = v;
        cmd_chan  = c;
        cmd_mode  = m;
        cmd_prio  = p;
    endtask

    logic [2:0] w_chan [6];
    logic [1:0] w_mode [6];
    logic       w_prio [6];
    logic [6:0] w_line [6];

    initial begin
        int idx;
        int k;
        int p;
        logic acc;
        logic rdy_exp;
        logic [10:0] be;

        compared   = 0;
        mismatched = 0;

        w_chan[0] = 3'd1; w_mode[0] = 2'b00; w_prio[0] = 1'b0; w_line[0] = 7'b0000001;
        w_chan[1] = 3'd2; w_mode[1] = 2'b01; w_prio[1] = 1'b1; w_line[1] = 7'b0000010;
        w_chan[2] = 3'd4; w_mode[2] = 2'b10; w_prio[2] = 1'b0; w_line[2] = 7'b0001000;
        w_chan[3] = 3'd5; w_mode[3] = 2'b11; w_prio[3] = 1'b1; w_line[3] = 7'b0010000;
        w_chan[4] = 3'd6; w_mode[4] = 2'b00; w_prio[4] = 1'b1; w_line[4] = 7'b0100000;
        w_chan[5] = 3'd7; w_mode[5] = 2'b10; w_prio[5] = 1'b0; w_line[5] = 7'b1000000;

        // Reset
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 2'b00, 1'b0);
        step();
        step();
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_bus", bus_now(), 11'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", issued_cnt, 16'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", cmd_ready, 1'b1);

        // Single command: chan 3, mode 01, prio 1
        drive(1'b1, 3'd3, 2'b01, 1'b1);
        step();
        drive(1'b0, 3'd0, 2'b00, 1'b0);
        chk("t1_accept_bus", bus_now(), 11'd0);
        chk("t1_accept_busy", busy, 1'b1);
        step();
        chk("t1_setup", bus_now(), bus_exp(7'b0000100, 2'b01, 1'b1, 1'b0));
        step();
        chk("t1_strobe0", bus_now(), bus_exp(7'b0000100, 2'b01, 1'b1, 1'b1));
        step();
        chk("t1_strobe1", bus_now(), bus_exp(7'b0000100, 2'b01, 1'b1, 1'b1));
        chk("t1_cnt_early", issued_cnt, 16'd0);
        step();
        chk("t1_release", bus_now(), 11'd0);
        chk("t1_cnt", issued_cnt, 16'd1);
        chk("t1_busy_rel", busy, 1'b1);
        step();
        chk("t1_idle_busy", busy, 1'b0);

        // Channel 0 with both select bits
        drive(1'b1, 3'd0, 2'b11, 1'b0);
        step();
        drive(1'b0, 3'd0, 2'b00, 1'b0);
        step();
        chk("t2_setup", bus_now(), bus_exp(7'b0, 2'b11, 1'b0, 1'b0));
        step();
        chk("t2_strobe0", bus_now(), bus_exp(7'b0, 2'b11, 1'b0, 1'b1));
        step();
        chk("t2_strobe1", bus_now(), bus_exp(7'b0, 2'b11, 1'b0, 1'b1));
        step();
        chk("t2_release", bus_now(), 11'd0);
        chk("t2_cnt", issued_cnt, 16'd2);
        step();

        // Six words with cmd_valid held: back-pressure and ordering
        idx = 0;
        drive(1'b1, w_chan[0], w_mode[0], w_prio[0]);
        for (int n = 0; n <= 26; n++) begin
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) idx++;
            if (idx < 6) drive(1'b1, w_chan[idx], w_mode[idx], w_prio[idx]);
            else drive(1'b0, 3'd0, 2'b00, 1'b0);
            rdy_exp = !(n == 4 || (n >= 6 && n <= 8));
            chk($sformatf("t3_ready_e%0d", n), cmd_ready, rdy_exp);
            be = 11'd0;
            if (n >= 1) begin
                k = (n - 1) / 4;
                p = (n - 1) % 4;
                if (k < 6 && p != 3)
                    be = bus_exp(w_line[k], w_mode[k], w_prio[k], (p != 0));
            end
            chk($sformatf("t3_bus_e%0d", n), bus_now(), be);
        end
        chk("t3_accepted", idx, 6);
        chk("t3_cnt", issued_cnt, 16'd8);
        chk("t3_busy", busy, 1'b0);

        // Reset mid-STROBE with two words queued
        drive(1'b1, w_chan[1], w_mode[1], w_prio[1]);
        step();
        drive(1'b1, w_chan[2], w_mode[2], w_prio[2]);
        step();
        drive(1'b1, w_chan[3], w_mode[3], w_prio[3]);
        step();
        drive(1'b0, 3'd0, 2'b00, 1'b0);
        chk("t4_in_strobe", strobe, 1'b1);
        rst_n = 1'b0;
        step();
        chk("t4_rst_bus", bus_now(), 11'd0);
        chk("t4_rst_cnt", issued_cnt, 16'd0);
        chk("t4_rst_busy", busy, 1'b0);
        chk("t4_rst_ready", cmd_ready, 1'b0);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            chk($sformatf("t4_quiet_%0d", n), bus_now(), 11'd0);
        end
        chk("t4_cnt_after", issued_cnt, 16'd0);
        chk("t4_busy_after", busy, 1'b0);
        chk("t4_ready_after", cmd_ready, 1'b1);

        // Counter wrap from 0xFFFF
        force dut.cnt_q = 16'hFFFF;
        step();
        release dut.cnt_q;
        step();
        chk("t5_preload", issued_cnt, 16'hFFFF);
        drive(1'b1, 3'd7, 2'b10, 1'b1);
        step();
        drive(1'b0, 3'd0, 2'b00, 1'b0);
        step();
        chk("t5_setup", bus_now(), bus_exp(7'b1000000, 2'b10, 1'b1, 1'b0));
        step();
        step();
        chk("t5_cnt_hold", issued_cnt, 16'hFFFF);
        step();
        chk("t5_wrap", issued_cnt, 16'h0000);
        chk("t5_release", bus_now(), 11'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
